// File: rtl/dsp_chain_2_fp16_sop2_scheduler.sv
// Round-robin front end for a shared 8-lane fp16 sum-of-two-products array:
// grants one requester per cycle, registers its operands and routes each result back by tag.
module dsp_chain_2_fp16_sop2_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 4,
  parameter int MAX_OUT = 8,
  parameter int DATA_W  = 1024,
  parameter int RES_W   = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [DATA_W-1:0]         dp_inp,
  input  logic [RES_W-1:0]          dp_outp,
  output logic                      rsp_valid,
  output logic [2:0]                rsp_id,
  output logic [RES_W-1:0]          rsp_data,
  output logic                      busy
);

  logic [2:0]              rr_ptr;
  logic [3:0]              out_cnt [NUM_REQ];
  logic [7:0]              elig;
  logic [7:0]              gnt;
  logic                    gnt_any;
  logic [2:0]              gnt_idx;
  logic [2:0]              rr_nxt;
  logic [DATA_W-1:0]       gnt_data;
  logic [LATENCY:0]        vld_p;
  logic [LATENCY:0][2:0]   id_p;
  logic                    cnt_nz;

  // Reset also gates eligibility so req_ready drops the moment reset asserts.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = reset & enable & req_valid[i] & (out_cnt[i] < 4'(MAX_OUT));
  end

  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && elig[idx[2:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[2:0];
      end
    end
  end

  always_comb begin
    gnt       = gnt_any ? (8'b1 << gnt_idx) : 8'b0;
    req_ready = gnt[NUM_REQ-1:0];
    rr_nxt    = (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
    gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) gnt_data = req_data[i*DATA_W +: DATA_W];
  end

  // Issue stage: operands of the accepted requester, zero on idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      dp_inp <= '0;
    end else begin
      if (gnt_any) rr_ptr <= rr_nxt;
      dp_inp <= gnt_data;
    end
  end

  // Tag pipe: the last stage lines up with dp_outp for the same operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p <= '0;
      id_p  <= '0;
    end else begin
      vld_p <= {vld_p[LATENCY-1:0], gnt_any};
      id_p  <= {id_p[LATENCY-1:0], gnt_idx};
    end
  end

  // Response stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= vld_p[LATENCY];
      rsp_id    <= id_p[LATENCY];
      rsp_data  <= vld_p[LATENCY] ? dp_outp : '0;
    end
  end

  // Outstanding counters; a response retires a slot only after it has been presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) out_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && !(rsp_valid && rsp_id == 3'(i)))
          out_cnt[i] <= out_cnt[i] + 4'd1;
        else if (!gnt[i] && rsp_valid && rsp_id == 3'(i))
          out_cnt[i] <= out_cnt[i] - 4'd1;
      end
    end
  end

  always_comb begin
    cnt_nz = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) cnt_nz = cnt_nz | (out_cnt[i] != 4'd0);
    busy = (|vld_p) | rsp_valid | cnt_nz;
  end

endmodule

// File: tb/tb_dsp_chain_2_fp16_sop2_scheduler.sv
// Scoreboard bench for the fp16 SOP2 scheduler: a per-cycle driver with a queue-based
// arbitration model pushes expected responses; a separate monitor pops and compares.
module tb_dsp_chain_2_fp16_sop2_scheduler;
  localparam int NUM_REQ = 4;
  localparam int LATENCY = 4;
  localparam int MAX_OUT = 2;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       enable = 1'b0;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*1024-1:0]    req_data = '0;
  logic [1023:0]              dp_inp;
  logic [255:0]               dp_outp = '0;
  logic                       rsp_valid;
  logic [2:0]                 rsp_id;
  logic [255:0]               rsp_data;
  logic                       busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dsp_chain_2_fp16_sop2_scheduler #(
    .NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .dp_inp(dp_inp), .dp_outp(dp_outp),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  typedef struct { int cyc; int id; logic [255:0] data; } rsp_t;
  typedef struct { int id; int cyc; } pend_t;

  rsp_t         sb[$];
  pend_t        pend[$];
  logic [255:0] sched [int];
  logic [1023:0] exp_din [int];
  int           glog[$];
  int           rr_m = 0;
  bit           prev_rstn = 1'b1;
  bit           mon_on = 1'b0;
  int           chk_cnt = 0;
  int           pass_cnt = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock cycle of stimulus: drive at the falling edge, then predict the grant.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic en, input logic rstn = 1'b1,
                      input bit force_tok = 1'b0, input logic [255:0] tok_in = '0,
                      input bit mark = 1'b0);
    int cnt [NUM_REQ];
    pend_t keep[$];
    int g;
    logic [NUM_REQ-1:0] er;
    logic [255:0] tok;
    @(negedge clk);
    req_valid = v;
    enable    = en;
    reset     = rstn;
    for (int w = 0; w < NUM_REQ*32; w++) req_data[w*32 +: 32] = $urandom;
    if (mark) req_data[2*1024 +: 8] = 8'hAB;
    dp_outp = sched.exists(cyc) ? sched[cyc] : rand256();
    #1;
    if (!rstn) begin
      sb.delete(); pend.delete(); sched.delete(); exp_din.delete(); rr_m = 0;
      if (prev_rstn) begin
        chk("rst req_ready", 256'(req_ready), '0);
        chk("rst dp_inp", dp_inp[255:0] | dp_inp[511:256] | dp_inp[767:512] | dp_inp[1023:768], '0);
        chk("rst rsp_valid", 256'(rsp_valid), '0);
        chk("rst rsp_id", 256'(rsp_id), '0);
        chk("rst rsp_data", rsp_data, '0);
        chk("rst busy", 256'(busy), '0);
      end
    end
    prev_rstn = rstn;
    for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
    foreach (pend[j]) if (pend[j].cyc >= cyc) begin
      keep.push_back(pend[j]);
      cnt[pend[j].id]++;
    end
    pend = keep;
    g = -1;
    if (rstn && en)
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (rr_m + k) % NUM_REQ;
        if (g < 0 && v[i] && cnt[i] < MAX_OUT) g = i;
      end
    er = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
    chk("req_ready", 256'(req_ready), 256'(er));
    for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) glog.push_back(i);
    if (g >= 0) begin
      rr_m = (g + 1) % NUM_REQ;
      tok = force_tok ? tok_in : rand256();
      sched[cyc + 1 + LATENCY] = tok;
      exp_din[cyc + 1] = req_data[g*1024 +: 1024];
      sb.push_back('{cyc + 2 + LATENCY, g, tok});
      pend.push_back('{g, cyc + 2 + LATENCY});
    end
  endtask

  logic [1023:0] m_ed;
  bit            m_ev;
  rsp_t          m_e;

  initial forever begin
    @(posedge clk);
    #1;
    if (mon_on) begin
      m_ed = exp_din.exists(cyc) ? exp_din[cyc] : '0;
      exp_din.delete(cyc);
      for (int c = 0; c < 4; c++)
        chk($sformatf("dp_inp[%0d]", c), dp_inp[c*256 +: 256], m_ed[c*256 +: 256]);
      chk("busy", 256'(busy), 256'(sb.size() > 0));
      m_ev = (sb.size() > 0) && (sb[0].cyc == cyc);
      chk("rsp_valid", 256'(rsp_valid), 256'(m_ev));
      if (m_ev) begin
        m_e = sb.pop_front();
        if (rsp_valid) begin
          chk("rsp_id", 256'(rsp_id), 256'(m_e.id));
          chk("rsp_data", rsp_data, m_e.data);
        end
      end else if (!rsp_valid) begin
        chk("rsp_data idle", rsp_data, '0);
      end
    end
  end

  initial begin
    step('1, 1'b1, 1'b0);
    mon_on = 1'b1;
    step('1, 1'b1, 1'b0);
    repeat (2) step('0, 1'b1);

    // Fairness from a fresh pointer.
    glog.delete();
    repeat (8) step('1, 1'b1);
    chk("fair count", 256'(glog.size()), 256'(8));
    for (int k = 0; k < 8 && k < glog.size(); k++)
      chk($sformatf("fair grant %0d", k), 256'(glog[k]), 256'(k % NUM_REQ));
    repeat (10) step('0, 1'b1);

    // Single operation on requester 2 with a known result word.
    step(4'b0100, 1'b1, 1'b1, 1'b1, 256'h1234, 1'b1);
    repeat (10) step('0, 1'b1);

    // Outstanding limit, including simultaneous accept and retire.
    repeat (16) step(4'b0010, 1'b1);
    repeat (10) step('0, 1'b1);

    // Drain with enable low.
    repeat (3) step('1, 1'b1);
    repeat (10) step('1, 1'b0);
    repeat (2) step('0, 1'b1);

    // Reset with operations in flight.
    repeat (4) step('1, 1'b1);
    repeat (2) step('1, 1'b1, 1'b0);
    repeat (8) step('0, 1'b1);
    glog.delete();
    step('1, 1'b1);
    chk("post-reset grant", 256'(glog.size() > 0 ? glog[0] : -1), 256'(0));
    repeat (10) step('0, 1'b1);

    repeat (400) step(NUM_REQ'($urandom), ($urandom_range(0, 7) != 0));
    repeat (12) step('0, 1'b1);
    chk("scoreboard empty", 256'(sb.size()), '0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/dsp_chain_2_fp16_sop2_scheduler.md
# dsp_chain_2_fp16_sop2_scheduler

Round-robin scheduler that shares one 8-lane fp16 sum-of-two-products multiplier array (1024-bit operand bus, 256-bit result bus, fixed pipeline latency, no stall input) between NUM_REQ requesters. It sits between the requesting engines and the array and owns three functions:
- grant arbitration;
- operand-bus registration;
- tag tracking, so each 256-bit result returns to the requester that issued it.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- LATENCY, 4: datapath cycles from dp_inp to matching dp_outp, ≥1.
- MAX_OUT, 8: maximum outstanding operations per requester, 1..15.
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = grants allowed; 0 = drain (no new grants).
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_data  input  NUM_REQ*1024  operands; requester i on bits [i*1024+1023 : i*1024].
- dp_inp  output  1024  operand bus to the multiplier array.
- dp_outp  input  256  result bus from the multiplier array.
- rsp_valid  output  1  result valid, one cycle per result; no backpressure.
- rsp_id  output  3  requester index owning rsp_data.
- rsp_data  output  256  registered copy of dp_outp.
- busy  output  1  any operation in flight or outstanding.

## Operation
- Accept: requester i is accepted in a cycle iff req_valid[i] and req_ready[i].
- Eligible: requester i is eligible iff enable, req_valid[i], and out_cnt[i] < MAX_OUT.
- Arbiter:
  - rr_ptr (3 bits, reset 0).
  - Grant goes to the first eligible index scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready is the one-hot grant. It is combinational from req_valid, enable, out_cnt and rr_ptr.
  - On accept, rr_ptr ← granted index + 1 (mod NUM_REQ). Otherwise rr_ptr holds.
- Issue register:
  - On accept, dp_inp ← req_data slice of the granted requester.
  - With no accept, dp_inp ← 0.
- Tag pipe:
  - LATENCY+1 stages of {valid, id}.
  - Stage 0 ← {accept, granted index}; stage n ← stage n-1 every cycle, unconditionally.
  - The final stage aligns with dp_outp for that operation.
- Response register:
  - rsp_valid ← final-stage valid.
  - rsp_id ← final-stage id.
  - rsp_data ← dp_outp when the final stage is valid, else rsp_data ← 0.
- Outstanding counters out_cnt[i] (4 bits):
  - +1 on accept of i; −1 when rsp_valid is asserted with rsp_id = i.
  - Both in the same cycle: unchanged.
  - Saturation is impossible by construction. A requester at MAX_OUT has req_ready low, even in the cycle its counter is decrementing (no bypass).
- Drain: enable = 0 blocks new grants only. In-flight operations complete normally and produce responses.
- busy = OR of all tag-pipe valids, rsp_valid, and (any out_cnt ≠ 0).
- Reset (asynchronous, any time including mid-operation):
  - req_ready = 0, dp_inp = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0.
  - rr_ptr = 0; all tag stages invalid; all out_cnt = 0.
  - In-flight results are discarded. dp_outp is ignored until newly issued tags arrive.

## Timing
- Accept at edge k → dp_inp carries operands during cycle k+1.
- Result on dp_outp during cycle k+1+LATENCY → rsp_valid/rsp_id/rsp_data high for exactly the cycle after edge k+LATENCY+1.
- Accept-to-response latency: LATENCY+1 edges (5 at default).
- Throughput: one accept per cycle sustained. Responses return in accept order, one per cycle, with no gaps beyond the accept gaps.
- req_ready is valid in the same cycle as req_valid, so zero-cycle accept is possible.
- Deassertion of enable takes effect the same cycle: no grant while enable = 0.
- busy falls the cycle after the last rsp_valid.

## Test plan
- Single op: reset released; req_valid[2] = 1 with data = 0x…AB for one cycle.
  - req_ready[2] = 1 that cycle; dp_inp = that data one cycle later.
  - Bench drives dp_outp = 0x1234 in the aligned cycle; rsp_valid = 1, rsp_id = 2, rsp_data = 0x1234 exactly 5 edges after accept.
  - busy returns to 0 afterwards.
- Fairness: all four req_valid held high for 8 cycles.
  - Grant order 0,1,2,3,0,1,2,3.
  - Responses arrive in the same order, back-to-back.
- Outstanding limit: MAX_OUT = 2, only req 1 valid, continuously.
  - Accepts at cycles 0 and 1; req_ready[1] = 0 until its first rsp_valid.
  - A new accept occurs the cycle after that response; no bypass in the response cycle.
- Drain: enable dropped while 3 ops are in flight.
  - No further req_ready.
  - 3 responses still emitted with correct ids; busy falls after the last one.
- Reset mid-flight: reset asserted low with 4 ops in the tag pipe.
  - All outputs read 0 immediately (asynchronous).
  - After release, no stale rsp_valid appears even if dp_outp is nonzero.
  - The next grant starts at index 0.
- Simultaneous accept and response for the same requester: out_cnt is unchanged; verify the counter through req_ready at the MAX_OUT boundary.
